// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: control/status bundle for the multi-channel divider (write port, sync, outputs).
// Carries no state; signals pass straight between the driver and the divider.
// Readback signals rd_ch/rd_half exist only when CLKDIV_READBACK_EN is defined.
interface clkdiv_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
);
    localparam int CH_W = ($clog2(NCH) > 0) ? $clog2(NCH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_half;
    logic             sync;
    logic [NCH-1:0]   clk_div;
    logic [NCH-1:0]   tick;

`ifdef CLKDIV_READBACK_EN
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_half;

    modport master (output wr_en, wr_ch, wr_half, sync, rd_ch,
                    input  clk_div, tick, rd_half);
    modport slave  (input  wr_en, wr_ch, wr_half, sync, rd_ch,
                    output clk_div, tick, rd_half);
`else
    modport master (output wr_en, wr_ch, wr_half, sync,
                    input  clk_div, tick);
    modport slave  (input  wr_en, wr_ch, wr_half, sync,
                    output clk_div, tick);
`endif
endinterface

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable dividers, 50% square wave plus one-cycle rising-edge tick.
// Latency: writes land in the shadow register at the next edge and take effect at the next wrap/sync.
// No backpressure: writes are always accepted (out-of-range channel ignored); CLKDIV_READBACK_EN adds rd_ch/rd_half.
module clkdiv_multi #(
    parameter int          NCH          = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned FREQ         = 50,
    parameter int unsigned DEFAULT_HALF = CLK_FREQ / (2 * FREQ)
) (
    input  logic          clk,
    input  logic          rst,
    clkdiv_multi_if.slave bus
);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Per channel: active half-period, shadow half-period, phase counter
    logic [CNT_W-1:0] act_half [NCH];
    logic [CNT_W-1:0] shd_half [NCH];
    logic [CNT_W-1:0] cnt      [NCH];
    logic [NCH-1:0]   div_q;
    logic [NCH-1:0]   tick_q;

    // Shadow half-period capture; channel index outside 0..NCH-1 matches no channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) shd_half[i] <= HALF_RST;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.wr_en && (int'(bus.wr_ch) == i)) shd_half[i] <= bus.wr_half;
            end
        end
    end

    // Channel engines: sync beats everything, then stopped/restart, then wrap, then count.
    // Active half only changes at a counter restart, so the counter never overshoots it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                act_half[i] <= HALF_RST;
                cnt[i]      <= '0;
            end
            div_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.sync) begin
                    cnt[i]      <= '0;
                    div_q[i]    <= 1'b0;
                    tick_q[i]   <= 1'b0;
                    act_half[i] <= shd_half[i];
                end else if (act_half[i] == '0) begin
                    // Stopped: wait for a non-zero shadow, then start in the low phase
                    cnt[i]    <= '0;
                    div_q[i]  <= 1'b0;
                    tick_q[i] <= 1'b0;
                    if (shd_half[i] != '0) act_half[i] <= shd_half[i];
                end else if (cnt[i] == act_half[i] - ONE) begin
                    cnt[i]      <= '0;
                    act_half[i] <= shd_half[i];
                    if (shd_half[i] == '0) begin
                        div_q[i]  <= 1'b0;
                        tick_q[i] <= 1'b0;
                    end else begin
                        div_q[i]  <= ~div_q[i];
                        tick_q[i] <= ~div_q[i];
                    end
                end else begin
                    cnt[i]    <= cnt[i] + ONE;
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.clk_div = div_q;
    assign bus.tick    = tick_q;

`ifdef CLKDIV_READBACK_EN
    logic [CNT_W-1:0] rd_q;

    // Registered readback of the active half-period; unknown channels read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (int'(bus.rd_ch) < NCH) begin
            rd_q <= act_half[bus.rd_ch];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.rd_half = rd_q;
`endif
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed bench for clkdiv_multi with NCH=4, DEFAULT_HALF=5.
// A second 3-channel instance has a permanent write aimed at a non-existent channel.
// Edge numbers count rising clk edges after reset release; outputs sampled 1 time unit after an edge.
module tb_clkdiv_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   now    = 0;

    always #5 clk = ~clk;

    clkdiv_multi_if #(.NCH(4), .CNT_W(16)) bus ();
    clkdiv_multi_if #(.NCH(3), .CNT_W(16)) bus3 ();

    clkdiv_multi #(.NCH(4), .CNT_W(16), .CLK_FREQ(1000), .FREQ(100)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    clkdiv_multi #(.NCH(3), .CNT_W(16), .CLK_FREQ(1000), .FREQ(100)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int e);
        repeat (e - now) @(posedge clk);
        #1;
        now = e;
    endtask

    // One-edge write pulse, consumes one edge
    task automatic write_at(input logic [1:0] ch, input logic [15:0] half);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = ch;
        bus.wr_half = half;
        goto(now + 1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_half  = '0;
        bus.sync     = 1'b0;
        bus3.wr_en   = 1'b1;
        bus3.wr_ch   = 2'd3;
        bus3.wr_half = 16'd1;
        bus3.sync    = 1'b0;
`ifdef CLKDIV_READBACK_EN
        bus.rd_ch    = 2'd1;
        bus3.rd_ch   = 2'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_div", 32'(bus.clk_div), 'b0000);
        chk("rst_tick", 32'(bus.tick), 'b0000);
        chk("rst_clk_div3", 32'(bus3.clk_div), 'b000);

        // 1. Default rate: first rise at edge 5, period 10
        release_rst();
        goto(4);
        chk("t1_e4_div", 32'(bus.clk_div), 'b0000);
        chk("t1_e4_tick", 32'(bus.tick), 'b0000);
        goto(5);
        chk("t1_e5_div", 32'(bus.clk_div), 'b1111);
        chk("t1_e5_tick", 32'(bus.tick), 'b1111);
        chk("oor_e5_div3", 32'(bus3.clk_div), 'b111);
        goto(6);
        chk("t1_e6_div", 32'(bus.clk_div), 'b1111);
        chk("t1_e6_tick", 32'(bus.tick), 'b0000);
        goto(10);
        chk("t1_e10_div", 32'(bus.clk_div), 'b0000);
        chk("oor_e10_div3", 32'(bus3.clk_div), 'b000);
        goto(15);
        chk("t1_e15_div", 32'(bus.clk_div), 'b1111);
        chk("t1_e15_tick", 32'(bus.tick), 'b1111);
        chk("oor_e15_div3", 32'(bus3.clk_div), 'b111);

        // 2. ch1 half=3 written at C=2: falls at 20, then period 6
        goto(17);
        write_at(2'd1, 16'd3);
        goto(20);
        chk("t2_e20_div", 32'(bus.clk_div), 'b0000);
        goto(23);
        chk("t2_e23_div", 32'(bus.clk_div), 'b0010);
        chk("t2_e23_tick", 32'(bus.tick), 'b0010);
        goto(25);
        chk("t2_e25_div", 32'(bus.clk_div), 'b1111);
        chk("t2_e25_tick", 32'(bus.tick), 'b1101);
        goto(26);
        chk("t2_e26_div", 32'(bus.clk_div), 'b1101);
        goto(29);
        chk("t2_e29_tick", 32'(bus.tick), 'b0010);
        goto(30);
        chk("t2_e30_div", 32'(bus.clk_div), 'b0010);

        // 3. ch2 stopped during its low phase, then restarted with half=2
        goto(40);
        write_at(2'd2, 16'd0);
        goto(45);
        chk("t3_e45_div", 32'(bus.clk_div), 'b1001);
        chk("t3_e45_tick", 32'(bus.tick), 'b1001);
        goto(55);
        chk("t3_e55_div", 32'(bus.clk_div), 'b1011);
        chk("t3_e55_tick", 32'(bus.tick), 'b1001);
        write_at(2'd2, 16'd2);
        goto(58);
        chk("t3_e58_div", 32'(bus.clk_div), 'b1001);
        goto(59);
        chk("t3_e59_div", 32'(bus.clk_div), 'b1111);
        chk("t3_e59_tick", 32'(bus.tick), 'b0110);

        // 4. ch0=4, ch3=7, one-cycle sync at edge 62
        write_at(2'd0, 16'd4);
        write_at(2'd3, 16'd7);
        bus.sync = 1'b1;
        goto(62);
        bus.sync = 1'b0;
        chk("t4_e62_div", 32'(bus.clk_div), 'b0000);
        chk("t4_e62_tick", 32'(bus.tick), 'b0000);
        goto(64);
        chk("t4_e64_div", 32'(bus.clk_div), 'b0100);
        goto(65);
        chk("t4_e65_div", 32'(bus.clk_div), 'b0110);
        chk("t4_e65_tick", 32'(bus.tick), 'b0010);
        goto(66);
        chk("t4_e66_div", 32'(bus.clk_div), 'b0011);
        chk("t4_e66_tick", 32'(bus.tick), 'b0001);
        goto(69);
        chk("t4_e69_div", 32'(bus.clk_div), 'b1101);
        chk("t4_e69_tick", 32'(bus.tick), 'b1000);

        // Held sync for edges 70..72 with a ch1=1 write on the first; ch1 then runs at clk/2
        bus.sync = 1'b1;
        write_at(2'd1, 16'd1);
        goto(72);
        chk("hold_e72_div", 32'(bus.clk_div), 'b0000);
        bus.sync = 1'b0;
        goto(73);
        chk("hold_e73_div", 32'(bus.clk_div), 'b0010);
        chk("hold_e73_tick", 32'(bus.tick), 'b0010);
        goto(74);
        chk("hold_e74_div", 32'(bus.clk_div), 'b0100);
        goto(75);
        chk("hold_e75_div", 32'(bus.clk_div), 'b0110);
        chk("hold_e75_tick", 32'(bus.tick), 'b0010);

        // 5. ch0 write coincident with its wrap at 76; ch3 back-to-back writes 9 then 3
        write_at(2'd0, 16'd2);
        write_at(2'd3, 16'd9);
        write_at(2'd3, 16'd3);
        goto(79);
        chk("wrap_e79_ch0", 32'(bus.clk_div[0]), 'b1);
        chk("b2b_e79_ch3", 32'(bus.clk_div[3]), 'b1);
        chk("b2b_e79_tick3", 32'(bus.tick[3]), 'b1);
        goto(80);
        chk("wrap_e80_ch0", 32'(bus.clk_div[0]), 'b0);
        goto(82);
        chk("wrap_e82_ch0", 32'(bus.clk_div[0]), 'b1);
        chk("wrap_e82_tick0", 32'(bus.tick[0]), 'b1);
        chk("b2b_e82_ch3", 32'(bus.clk_div[3]), 'b0);
        goto(85);
        chk("b2b_e85_ch3", 32'(bus.clk_div[3]), 'b1);
        chk("b2b_e85_tick3", 32'(bus.tick[3]), 'b1);
        chk("oor_e85_div3", 32'(bus3.clk_div), 'b111);

        // 6. Async reset mid-cycle while ch3 is high and ticking
        #3;
        rst = 1'b1;
        #1;
        chk("arst_div", 32'(bus.clk_div), 'b0000);
        chk("arst_tick", 32'(bus.tick), 'b0000);
`ifdef CLKDIV_READBACK_EN
        chk("arst_rd_half", 32'(bus.rd_half), 'd0);
`endif
        release_rst();
`ifdef CLKDIV_READBACK_EN
        goto(1);
        chk("rd_half_ch1", 32'(bus.rd_half), 'd5);
`endif
        goto(4);
        chk("rerst_e4_div", 32'(bus.clk_div), 'b0000);
        goto(5);
        chk("rerst_e5_div", 32'(bus.clk_div), 'b1111);
        chk("rerst_e5_tick", 32'(bus.tick), 'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
